// File: rtl/mm_front_end_if.sv
// Memory read port and output stream of the co-processor input stage.
// master = the front end, slave = memory model plus downstream datapath.
`timescale 1ns/1ps
interface mm_front_end_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_en, mem_addr, out_data, out_valid,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_en, mem_addr, out_data, out_valid,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/mm_front_end.sv
// Reads `size` consecutive words from the input buffer memory and streams them out.
// A 2-entry FIFO hides the 1-cycle read latency so back-pressure never drops data.
`timescale 1ns/1ps
module mm_front_end #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            start,
    input  logic [ADDR_W:0] size,
    output logic            busy,
    output logic            done,
    mm_front_end_if.master  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    logic [1:0]        state;
    logic [ADDR_W:0]   size_q;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W:0]   remaining;
    logic              inflight;

    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              pop;
    logic              issue;
    logic              last_issue;
    logic              last_pop;
    logic [2:0]        credit;

    // A read may only issue if its word is guaranteed a FIFO slot when it returns.
    assign pop        = bus.out_valid && bus.out_ready;
    assign credit     = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == READ) && (rd_cnt < size_q) && (credit < 3'd2);
    assign last_issue = issue && ((rd_cnt + ONE) == size_q);
    assign last_pop   = (state == DRAIN) && pop && (remaining == ONE);

    assign bus.mem_en    = issue;
    assign bus.mem_addr  = rd_cnt[ADDR_W-1:0];
    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign bus.out_data  = fifo_mem[rd_ptr];
    assign busy          = (state != IDLE);

    // NOTE: registered state uses <= so every reader sees the pre-edge value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            size_q    <= '0;
            rd_cnt    <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue)
                rd_cnt <= rd_cnt + ONE;
            if (pop)
                remaining <= remaining - ONE;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (size == '0) begin
                            done <= 1'b1;
                        end else begin
                            size_q    <= size;
                            remaining <= size;
                            rd_cnt    <= '0;
                            state     <= READ;
                        end
                    end
                end
                READ: begin
                    if (last_issue)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (last_pop) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the two FIFO words are reset so out_data reads 0 out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_mem[wr_ptr] <= bus.mem_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;

            case ({inflight, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_mm_front_end.sv
// Bench for mm_front_end: a memory model, random back-pressure, and a word-level
// reference (expected word queue plus issued/popped counts) compared every cycle.
`timescale 1ns/1ps
module tb_mm_front_end;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            start;
    logic [ADDR_W:0] size;
    logic            busy;
    logic            done;

    mm_front_end_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mm_front_end #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .start   (start),
        .size    (size),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    logic [DATA_W-1:0] mem [DEPTH];

    // Input buffer memory: one cycle read latency.
    always @(posedge aclk) begin
        if (bus.mem_en)
            bus.mem_rdata <= mem[bus.mem_addr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] pop_log[$];
    bit                in_job     = 1'b0;
    bit                done_due   = 1'b0;
    bit                ready_hi   = 1'b0;
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    int                job_size   = 0;
    int                issued     = 0;
    int                popped     = 0;
    int                job_cyc    = 0;
    int                last_len   = 0;
    int                done_count = 0;
    int                en_count   = 0;
    int                hits [DEPTH];
    int                mode       = 0;
    int                cyc        = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit   pop;
        bit   idle_at_top;
        logic exp_en;
        pop         = bus.out_valid && bus.out_ready;
        idle_at_top = !in_job;

        check("busy", 64'(busy), 64'(in_job));
        check("done", 64'(done), 64'(done_due));
        if (done)
            done_count++;
        done_due = 1'b0;

        if (in_job)
            job_cyc++;
        if (prev_stall) begin
            check("stall_valid", 64'(bus.out_valid), 64'(1));
            check("stall_data", 64'(bus.out_data), 64'(prev_data));
        end
        if (!in_job)
            check("idle_valid", 64'(bus.out_valid), 64'(0));
        else if (job_cyc < 3)
            check("early_valid", 64'(bus.out_valid), 64'(0));
        else if (job_cyc == 3)
            check("first_valid", 64'(bus.out_valid), 64'(1));
        if (bus.out_valid && exp_q.size() != 0)
            check("out_data", 64'(bus.out_data), 64'(exp_q[0]));

        // At most two words may be outstanding (in flight or buffered) after an issue.
        exp_en = in_job && (issued < job_size) && ((issued - popped - int'(pop)) < 2);
        check("mem_en", 64'(bus.mem_en), 64'(exp_en));
        if (bus.mem_en) begin
            check("mem_addr", 64'(bus.mem_addr), 64'(issued));
            hits[bus.mem_addr]++;
            issued++;
            en_count++;
        end

        if (pop && exp_q.size() != 0) begin
            pop_log.push_back(bus.out_data);
            void'(exp_q.pop_front());
            popped++;
            if (exp_q.size() == 0) begin
                done_due = 1'b1;
                in_job   = 1'b0;
                last_len = job_cyc;
                if (ready_hi)
                    check("job_len", 64'(job_cyc), 64'(job_size + 2));
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;

        if (idle_at_top && start) begin
            if (size == '0) begin
                done_due = 1'b1;
            end else begin
                in_job   = 1'b1;
                job_size = int'(size);
                issued   = 0;
                popped   = 0;
                job_cyc  = 0;
                ready_hi = (mode == 0);
                exp_q.delete();
                for (int i = 0; i < job_size; i++)
                    exp_q.push_back(mem[i]);
            end
        end
    endtask

    task automatic tick(input logic st, input logic [ADDR_W:0] sz);
        @(posedge aclk);
        #1;
        start = st;
        size  = sz;
        case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ((cyc % 3) == 0);
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        cyc++;
        @(negedge aclk);
        compare();
    endtask

    // Starts a job and returns in the cycle before its done pulse (or on timeout).
    task automatic run_job(input int sz, input int md, input int poke_at);
        int n;
        mode = md;
        tick(1'b1, (ADDR_W + 1)'(sz));
        n = 0;
        while (!done_due && n < 4000) begin
            if (n == poke_at)
                tick(1'b1, (ADDR_W + 1)'(5));
            else
                tick(1'b0, (ADDR_W + 1)'(sz));
            n++;
        end
        if (!done_due) begin
            check("job_timeout", 64'(0), 64'(1));
            in_job = 1'b0;
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int e0;
        int bad;
        aresetn       = 1'b0;
        start         = 1'b0;
        size          = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = '0;
            hits[i] = 0;
        end

        #1;
        check("rst_mem_en", 64'(bus.mem_en), 64'(0));
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (2) tick(1'b0, '0);

        // Streaming, 4 words, ready held high
        for (int i = 0; i < 64; i++)
            mem[i] = 32'hA0 + 32'(i);
        pop_log.delete();
        run_job(4, 0, -1);
        check("stream_len", 64'(pop_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("stream_word", 64'(pop_log[i]), 64'(32'hA0 + 32'(i)));
        check("stream_done_cycle", 64'(last_len), 64'(6));

        // Back-to-back: start again in the done cycle with one word
        pop_log.delete();
        d0 = done_count;
        run_job(1, 0, -1);
        tick(1'b0, '0);
        check("b2b_word", 64'(pop_log.size() > 0 ? pop_log[0] : '1), 64'(32'hA0));
        check("b2b_dones", 64'(done_count - d0), 64'(2));

        // Zero size
        d0 = done_count;
        e0 = en_count;
        run_job(0, 0, -1);
        repeat (3) tick(1'b0, '0);
        check("zero_done", 64'(done_count - d0), 64'(1));
        check("zero_mem_en", 64'(en_count - e0), 64'(0));

        // Back-pressure pattern 1,0,0 repeating
        for (int i = 0; i < 64; i++)
            mem[i] = $urandom;
        pop_log.delete();
        run_job(8, 1, -1);
        tick(1'b0, '0);
        check("bp_count", 64'(pop_log.size()), 64'(8));
        for (int i = 0; i < 8 && i < pop_log.size(); i++)
            check("bp_word", 64'(pop_log[i]), 64'(mem[i]));

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 64; i++)
                mem[i] = $urandom;
            run_job($urandom_range(1, 40), $urandom_range(0, 2), $urandom_range(0, 10));
        end
        tick(1'b0, '0);

        // Full address range with an ignored start mid-job
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = $urandom;
            hits[i] = 0;
        end
        run_job(DEPTH, 0, 100);
        tick(1'b0, '0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (hits[i] != 1)
                bad++;
        check("full_range_hits", 64'(bad), 64'(0));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 64; i++)
            mem[i] = $urandom;
        mode = 2;
        tick(1'b1, (ADDR_W + 1)'(20));
        repeat (8) tick(1'b0, '0);
        @(posedge aclk);
        #3 aresetn = 1'b0;
        #1;
        check("arst_mem_en", 64'(bus.mem_en), 64'(0));
        check("arst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("arst_out_valid", 64'(bus.out_valid), 64'(0));
        check("arst_out_data", 64'(bus.out_data), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        in_job     = 1'b0;
        done_due   = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        d0 = done_count;
        repeat (5) tick(1'b0, '0);
        check("arst_no_done", 64'(done_count - d0), 64'(0));

        // Recovery after reset
        pop_log.delete();
        run_job(3, 0, -1);
        tick(1'b0, '0);
        check("recover_count", 64'(pop_log.size()), 64'(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
